// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: working-variable bundle, round constants,
// standard initial hash value and the FIPS 180-4 logical functions.
package sha256_pkg;

  // Working variables a..h, packed so a occupies the most significant word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam int unsigned NUM_ROUNDS = 64;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: consumes K[t] and W[t] and
// advances the working variables a..h by one step.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
  assign t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);

  assign nxt = '{
    a: t1 + t2,
    b: cur.a,
    c: cur.b,
    d: cur.c,
    e: cur.d + t1,
    f: cur.e,
    g: cur.f,
    h: cur.g
  };

endmodule

// File: rtl/sha256.sv
// Single-block SHA-256 compression: fully unrolled 64-round datapath with the
// updated chaining value registered once per clock (1-cycle latency).
module sha256
  import sha256_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  input  logic [447:0] originalValue,
  input  logic [63:0]  length,
  input  logic [31:0]  hash0In,
  input  logic [31:0]  hash1In,
  input  logic [31:0]  hash2In,
  input  logic [31:0]  hash3In,
  input  logic [31:0]  hash4In,
  input  logic [31:0]  hash5In,
  input  logic [31:0]  hash6In,
  input  logic [31:0]  hash7In,
  output logic [31:0]  hash0Out,
  output logic [31:0]  hash1Out,
  output logic [31:0]  hash2Out,
  output logic [31:0]  hash3Out,
  output logic [31:0]  hash4Out,
  output logic [31:0]  hash5Out,
  output logic [31:0]  hash6Out,
  output logic [31:0]  hash7Out,
  output logic [255:0] hashedValue
);

  logic [511:0] block;
  logic [31:0]  w [0:63];
  work_t        chain_in;
  work_t        stage [0:64];
  work_t        digest_d;
  work_t        digest_q;

  assign block    = {originalValue, length};
  assign chain_in = '{a: hash0In, b: hash1In, c: hash2In, d: hash3In,
                      e: hash4In, f: hash5In, g: hash6In, h: hash7In};

  // Message schedule: first 16 words come straight from the block, big-endian.
  for (genvar t = 0; t < 16; t++) begin : g_w_load
    assign w[t] = block[511 - 32*t -: 32];
  end
  for (genvar t = 16; t < NUM_ROUNDS; t++) begin : g_w_expand
    assign w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
  end

  assign stage[0] = chain_in;
  for (genvar t = 0; t < NUM_ROUNDS; t++) begin : g_round
    sha256_round u_round (
      .cur (stage[t]),
      .k   (K[t]),
      .w   (w[t]),
      .nxt (stage[t+1])
    );
  end

  assign digest_d = '{
    a: hash0In + stage[64].a, b: hash1In + stage[64].b,
    c: hash2In + stage[64].c, d: hash3In + stage[64].d,
    e: hash4In + stage[64].e, f: hash5In + stage[64].f,
    g: hash6In + stage[64].g, h: hash7In + stage[64].h
  };

  // NOTE: non-blocking assignment in the clocked block; the async reset clears
  // the output register without waiting for a clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) digest_q <= '0;
    else         digest_q <= digest_d;
  end

  assign hash0Out    = digest_q.a;
  assign hash1Out    = digest_q.b;
  assign hash2Out    = digest_q.c;
  assign hash3Out    = digest_q.d;
  assign hash4Out    = digest_q.e;
  assign hash5Out    = digest_q.f;
  assign hash6Out    = digest_q.g;
  assign hash7Out    = digest_q.h;
  assign hashedValue = digest_q;

endmodule

// File: tb/tb_sha256.sv
// Self-checking bench for sha256: a loop-based reference compression model
// scored every cycle, plus known digests of standard test messages.
module tb_sha256;

  logic         clock;
  logic         resetn;
  logic [447:0] originalValue;
  logic [63:0]  length;
  logic [31:0]  hin  [8];
  logic [31:0]  hout [8];
  logic [255:0] hashedValue;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] STD_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_HELLO =
    256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [447:0] M_HELLO = {88'h68656c6c6f20776f726c64, 1'b1, 359'b0};
  localparam logic [447:0] M_ABC   = {24'h616263, 1'b1, 423'b0};
  localparam logic [447:0] M_EMPTY = {1'b1, 447'b0};
  localparam logic [447:0] M_TWO1  = {
    128'h61626364626364656364656664656667,
    128'h65666768666768696768696a68696a6b,
    128'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f,
    64'h6d6e6f706e6f7071};

  sha256 dut (
    .clock         (clock),
    .resetn        (resetn),
    .originalValue (originalValue),
    .length        (length),
    .hash0In       (hin[0]),
    .hash1In       (hin[1]),
    .hash2In       (hin[2]),
    .hash3In       (hin[3]),
    .hash4In       (hin[4]),
    .hash5In       (hin[5]),
    .hash6In       (hin[6]),
    .hash7In       (hin[7]),
    .hash0Out      (hout[0]),
    .hash1Out      (hout[1]),
    .hash2Out      (hout[2]),
    .hash3Out      (hout[3]),
    .hash4Out      (hout[4]),
    .hash5Out      (hout[5]),
    .hash6Out      (hout[6]),
    .hash7Out      (hout[7]),
    .hashedValue   (hashedValue)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model written straight from the algorithm description.
  localparam logic [31:0] RK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [511:0] m, input logic [255:0] hv);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + RK[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] words_out();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hout[i];
    return r;
  endfunction

  function automatic logic [255:0] words_in();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[i];
    return r;
  endfunction

  // Scoreboard: expected register contents track edges and the async reset.
  logic [255:0] exp_q;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) exp_q = '0;
    else         exp_q = ref_compress({originalValue, length}, words_in());
  end

  bit scoring = 1'b0;
  always @(negedge clock) begin
    if (scoring) begin
      check("cycle hashedValue", hashedValue, exp_q);
      check("cycle hashNOut", words_out(), exp_q);
    end
  end

  task automatic drive(input logic [447:0] ov, input logic [63:0] len, input logic [255:0] hv);
    originalValue = ov;
    length        = len;
    for (int i = 0; i < 8; i++) hin[i] = hv[255 - 32*i -: 32];
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  logic [255:0] mid;

  initial begin
    resetn = 1'b0;
    drive(M_HELLO, 64'd88, STD_IV);

    // Model pinned against known digests.
    check("model abc", ref_compress({M_ABC, 64'd24}, STD_IV), D_ABC);
    check("model empty", ref_compress({M_EMPTY, 64'd0}, STD_IV), D_EMPTY);
    check("model two-block",
          ref_compress({448'b0, 64'd448},
                       ref_compress({M_TWO1, 64'h8000000000000000}, STD_IV)), D_TWO);

    #3;
    check("reset state", hashedValue, '0);
    check("reset state words", words_out(), '0);
    scoring = 1'b1;
    tick();
    check("reset held over edge", hashedValue, '0);

    resetn = 1'b1;
    #1 check("release without edge", hashedValue, '0);
    tick();
    check("hello world", hashedValue, D_HELLO);
    check("hello hash0Out", {224'b0, hout[0]}, {224'b0, 32'hb94d27b9});
    check("hello hash7Out", {224'b0, hout[7]}, {224'b0, 32'he2efcde9});

    // Back-to-back blocks on consecutive edges.
    drive(M_ABC, 64'd24, STD_IV);
    #1 check("input change between edges", hashedValue, D_HELLO);
    tick();
    check("abc", hashedValue, D_ABC);
    drive(M_EMPTY, 64'd0, STD_IV);
    tick();
    check("empty", hashedValue, D_EMPTY);

    // Asynchronous reset mid-cycle with a valid result on the outputs.
    drive(M_ABC, 64'd24, STD_IV);
    tick();
    check("abc before reset", hashedValue, D_ABC);
    #1 resetn = 1'b0;
    #1 check("async reset clears", hashedValue, '0);
    check("async reset clears words", words_out(), '0);
    tick();
    check("reset low over edge", hashedValue, '0);
    resetn = 1'b1;
    tick();
    check("first edge after release", hashedValue, D_ABC);

    // Two-block chaining: block-1 result fed back as block-2 chaining value.
    drive(M_TWO1, 64'h8000000000000000, STD_IV);
    tick();
    mid = words_out();
    drive(448'b0, 64'd448, mid);
    tick();
    check("two-block digest", hashedValue, D_TWO);

    // Arbitrary blocks and chaining values, back to back, scored by the model.
    for (int i = 0; i < 6; i++) begin
      logic [447:0] ov;
      logic [255:0] hv;
      for (int j = 0; j < 14; j++) ov[447 - 32*j -: 32] = $urandom;
      for (int j = 0; j < 8; j++)  hv[255 - 32*j -: 32] = $urandom;
      drive(ov, {$urandom, $urandom}, hv);
      tick();
    end
    drive(448'hffffffff_ffffffff, 64'hffffffffffffffff, {256{1'b1}});
    tick();
    @(negedge clock);
    #1;
    scoring = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256.md
# sha256

Single-block SHA-256 compression engine for the FPGA miner datapath. It takes one caller-padded 512-bit message block and a 256-bit chaining value (the standard IV or a previous block's result). It computes the 64-round SHA-256 compression combinationally and registers the updated chaining value on the clock edge. Multi-block messages are built by feeding the outputs back as the next block's chaining inputs.

## Interface
- No parameters.
- `clock`  in  1  single system clock, rising-edge active.
- `resetn`  in  1  asynchronous, active-low reset.
- `originalValue`  in  448  message block bits 511..64, already padded by the caller (message, `1`, zeros).
- `length`  in  64  message block bits 63..0, the message bit length, big-endian.
- `hash0In`..`hash7In`  in  32 each  chaining value H0..H7 for this block.
- `hash0Out`..`hash7Out`  out  32 each  updated chaining value H0'..H7'.
- `hashedValue`  out  256  {`hash0Out`, …, `hash7Out`}, H0 in bits 255..224.

## Operation
- Block M = {`originalValue`, `length`}.
- Word W[0] = M[511:480], through W[15] = M[31:0].
- The block does no padding and no length checking.
- Schedule: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] for t = 16..63.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Working variables a..h initialise to `hash0In`..`hash7In`.
- Round t, for t = 0..63:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
- Σ0 = ROTR2 ^ ROTR13 ^ ROTR22.
- Σ1 = ROTR6 ^ ROTR11 ^ ROTR25.
- Ch = (e&f) ^ (~e&g).
- Maj = (a&b) ^ (a&c) ^ (b&c).
- K[t] are the FIPS 180-4 round constants.
- Result: `hashNOut` = `hashNIn` + final working variable (a..h respectively).
- All additions are 32-bit modulo 2^32; carries are discarded.
- Round logic is fully unrolled and combinational. Only the eight output words are registered; there is no FSM, no handshake, and no start/done.

## Timing
- Latency: 1 clock.
- Inputs stable before rising edge k produce outputs valid after edge k.
- Outputs hold until the next rising edge and update every edge, so a new block may be applied every cycle (throughput 1 block/clock).
- `resetn` low forces all `hashNOut` and `hashedValue` to 0 immediately, independent of `clock`.
- Outputs stay 0 while `resetn` is low.
- The first rising edge after `resetn` rises captures the current inputs.
- Reset mid-stream discards the pending result; no partial state survives.
- Input changes between edges have no effect on the outputs until the next edge.
- The critical path is the full 64-round chain. Synthesis timing constrains the achievable clock; this is accepted for this block.

## Structure
- Shared package `sha256_pkg` holds:
  - K[0:63] constant array.
  - Standard IV constants (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
  - Functions `ch`, `maj`, `bsig0`, `bsig1`, `ssig0`, `ssig1`.
- Sub-module `sha256_round`:
  - Inputs: a..h, K[t], W[t].
  - Outputs: next a..h.
  - Instantiated 64 times in a generate loop.
- Message schedule is a generate loop in the top level.

## Test plan
- "hello world": `originalValue` = {88'h68656c6c6f20776f726c64, 1'b1, 359'b0}, `length` = 88, IV on `hash*In` → after one edge `hashedValue` = b94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9.
- "abc": {24'h616263, 1'b1, 423'b0}, `length` = 24, IV → ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: {1'b1, 447'b0}, `length` = 0, IV → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Back-to-back: apply "abc" then empty message on consecutive edges → outputs show each digest exactly one edge after its inputs, with no mixing.
- Reset: with the "abc" result on the outputs, drive `resetn` low between edges → all outputs 0 at once with no clock edge. Release → the next edge yields the digest of the current inputs.
- Chaining: two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits, two padded blocks; second block's `length` = 448). Feed block-1 outputs into `hash*In` for block 2 → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
